hack_rom_loader: RTL and testbench

Upstream loader for the Hack `Computer`. It accepts a framed byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words. Each word is written into instruction ROM at consecutive addresses starting at 0. The block drives the Computer's active-high `cpu_reset` for the whole load and releases it only after a frame passes its checksum.

---
 rtl/hack_rom_loader.sv | 171 +++++++++++++++++
 tb/tb_hack_rom_loader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_rom_loader.sv
// hack_rom_loader
//
// Upstream loader for the Hack Computer. Receives a framed byte stream
//   MAGIC, LEN_HI, LEN_LO, LEN x {word_hi, word_lo}, CHK
// over a valid/ready handshake. It assembles big-endian 16-bit words and
// writes them to instruction ROM at consecutive addresses from 0. The
// Computer is held in reset (cpu_reset=1) for the whole load. It is released
// only after the frame's modulo-256 byte sum matches CHK.
//
// Handshake: a byte moves on a rising clk edge where in_valid && in_ready.
// in_ready is held low only while reset is asserted. The loader never
// back-pressures after that, and in_valid may drop for any number of cycles
// in any state.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   in_valid   in   byte-stream valid
//   in_data    in   byte-stream data [7:0]
//   in_ready   out  loader accepts a byte
//   rom_we     out  one-cycle ROM write strobe
//   rom_addr   out  ROM write address [ADDR_W-1:0]
//   rom_wdata  out  ROM write data [15:0]
//   cpu_reset  out  active-high reset to the Computer
//   done       out  last frame loaded and verified
//   error      out  last frame rejected
//   word_count out  words written in the current/last frame [ADDR_W:0]
//
// All outputs are registered. The FSM state is the internal signal 'state'
// (type state_t), so checkers can bind to it directly.
module hack_rom_loader #(
  parameter int          ADDR_W = 15,
  parameter logic [7:0]  MAGIC  = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CHK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam int unsigned     MAX_LEN = 32'd1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state;
  logic [7:0]        len_hi;   // first length byte, held until LEN_LO
  logic [7:0]        hi_byte;  // high byte of the word being assembled
  logic [7:0]        sum;      // modulo-256 sum of word bytes
  logic [ADDR_W:0]   len_q;    // frame length in words

  logic              accept;
  logic [31:0]       len_req;
  logic [ADDR_W:0]   cnt_next;

  assign accept   = in_valid && in_ready;
  assign len_req  = {16'd0, len_hi, in_data};
  assign cnt_next = word_count + CNT_ONE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      in_ready   <= 1'b0;
      rom_we     <= 1'b0;
      rom_addr   <= '0;
      rom_wdata  <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
      len_hi     <= '0;
      hi_byte    <= '0;
      sum        <= '0;
      len_q      <= '0;
    end else begin
      in_ready <= 1'b1;
      rom_we   <= 1'b0;

      // The address moves on in the cycle after a write strobe, so rom_addr
      // holds the written address while rom_we is high. The next DATA_LO
      // byte is at least two cycles later (DATA_HI sits in between), so the
      // increment always lands first. It wraps only after the final write of
      // a full 2^ADDR_W-word frame, where the address value does not matter.
      if (rom_we) begin
        rom_addr <= rom_addr + 1'b1;
      end

      if (accept) begin
        case (state)
          // IDLE, DONE and ERROR behave alike: only MAGIC starts a frame.
          // A MAGIC byte in DONE puts the running Computer back into reset.
          S_IDLE, S_DONE, S_ERROR: begin
            if (in_data == MAGIC) begin
              state      <= S_LEN_HI;
              cpu_reset  <= 1'b1;
              done       <= 1'b0;
              error      <= 1'b0;
              word_count <= '0;
              sum        <= '0;
              rom_addr   <= '0;
            end
          end

          S_LEN_HI: begin
            len_hi <= in_data;
            state  <= S_LEN_LO;
          end

          S_LEN_LO: begin
            len_q <= (ADDR_W+1)'(len_req);
            if (len_req == 32'd0) begin
              state <= S_CHK;
            end else if (len_req > MAX_LEN) begin
              state <= S_ERROR;
              error <= 1'b1;
            end else begin
              state <= S_DATA_HI;
            end
          end

          S_DATA_HI: begin
            hi_byte <= in_data;
            sum     <= sum + in_data;
            state   <= S_DATA_LO;
          end

          S_DATA_LO: begin
            rom_we     <= 1'b1;
            rom_wdata  <= {hi_byte, in_data};
            word_count <= cnt_next;
            sum        <= sum + in_data;
            state      <= (cnt_next == len_q) ? S_CHK : S_DATA_HI;
          end

          S_CHK: begin
            if (sum == in_data) begin
              state     <= S_DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              // cpu_reset stays high so a bad image never runs. Words
              // already written stay in ROM.
              state <= S_ERROR;
              error <= 1'b1;
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hack_rom_loader.sv
// Testbench for hack_rom_loader (ADDR_W=15, MAGIC=A5).
// A negedge monitor checks every rom_we strobe against exp_q, which holds
// {addr, data} entries that each test pushes before driving its frame.
module tb_hack_rom_loader;

  localparam int ADDR_W = 15;
  localparam int W      = ADDR_W + 16;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];

  hack_rom_loader #(.ADDR_W(ADDR_W), .MAGIC(8'hA5)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .rom_we     (rom_we),
    .rom_addr   (rom_addr),
    .rom_wdata  (rom_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rom_we === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got addr=%0h data=%04h, required no write",
                 rom_addr, rom_wdata);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({rom_addr, rom_wdata} !== e) begin
          n_err++;
          $display("FAIL rom_write: got addr=%0h data=%04h, required addr=%0h data=%04h",
                   rom_addr, rom_wdata, e[W-1:16], e[15:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    while (in_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (in_ready !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL ready_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waited);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic apply_reset();
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [15:0] d);
    exp_q.push_back({a, d});
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    n_cmp++; if (cpu_reset !== 1'b1) begin n_err++; $display("FAIL rst_cpu_reset: got %b, required 1", cpu_reset); end
    n_cmp++; if (in_ready !== 1'b0)  begin n_err++; $display("FAIL rst_in_ready: got %b, required 0", in_ready); end
    n_cmp++; if ({rom_we, done, error} !== 3'b000) begin n_err++; $display("FAIL rst_flags: got we/done/err=%b, required 000", {rom_we, done, error}); end
    n_cmp++; if (word_count !== '0 || rom_addr !== '0 || rom_wdata !== '0) begin
      n_err++; $display("FAIL rst_regs: got cnt=%0d addr=%0h data=%04h, required 0", word_count, rom_addr, rom_wdata);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL ready_before_edge: got %b, required 0", in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_release: got %b, required 1", in_ready); end
    n_cmp++; if (cpu_reset !== 1'b1) begin n_err++; $display("FAIL cpu_reset_idle: got %b, required 1", cpu_reset); end
  endtask

  // Word bytes EC+10+E3+08 = 0x1E7, so the matching checksum is 0xE7.
  task automatic test_two_word();
    expect_write(15'd0, 16'hEC10);
    expect_write(15'd1, 16'hE308);
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'hEC, 0);
    send_byte(8'h10, 0);
    n_cmp++; if ({rom_we, rom_addr, rom_wdata} !== {1'b1, 15'd0, 16'hEC10}) begin
      n_err++; $display("FAIL first_write: got we=%b addr=%0h data=%04h, required 1/0/EC10", rom_we, rom_addr, rom_wdata);
    end
    n_cmp++; if (word_count !== 16'd1) begin n_err++; $display("FAIL count_with_we: got %0d, required 1", word_count); end
    send_byte(8'hE3, 0);
    n_cmp++; if (rom_we !== 1'b0 || rom_addr !== 15'd1) begin
      n_err++; $display("FAIL addr_advance: got we=%b addr=%0h, required 0/1", rom_we, rom_addr);
    end
    send_byte(8'h08, 0);
    n_cmp++; if (done !== 1'b0 || cpu_reset !== 1'b1) begin
      n_err++; $display("FAIL before_chk: got done=%b cpu_reset=%b, required 0/1", done, cpu_reset);
    end
    send_byte(8'hE7, 0);
    n_cmp++; if ({done, cpu_reset, error} !== 3'b100) begin
      n_err++; $display("FAIL release: got done/cpu_reset/err=%b, required 100", {done, cpu_reset, error});
    end
    n_cmp++; if (word_count !== 16'd2) begin n_err++; $display("FAIL count_two: got %0d, required 2", word_count); end
    @(negedge clk);
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL writes_missing_two: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_magic_in_done();
    send_byte(8'hA5, 0);
    n_cmp++; if ({done, cpu_reset} !== 2'b01) begin
      n_err++; $display("FAIL magic_in_done: got done/cpu_reset=%b, required 01", {done, cpu_reset});
    end
    // MAGIC inside a frame is data: word A5A5, sum 0x14A -> 4A.
    expect_write(15'd0, 16'hA5A5);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hA5, 0);
    send_byte(8'hA5, 0);
    send_byte(8'h4A, 0);
    n_cmp++; if ({done, cpu_reset, error} !== 3'b100 || word_count !== 16'd1) begin
      n_err++; $display("FAIL magic_as_data: got done/cpu_reset/err=%b cnt=%0d, required 100/1", {done, cpu_reset, error}, word_count);
    end
    @(negedge clk);
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL writes_missing_magic: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_bad_checksum();
    expect_write(15'd0, 16'hEC10);
    expect_write(15'd1, 16'hE308);
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'hEC, 0);
    send_byte(8'h10, 0);
    send_byte(8'hE3, 0);
    send_byte(8'h08, 0);
    send_byte(8'h00, 0);
    n_cmp++; if ({done, cpu_reset, error} !== 3'b011) begin
      n_err++; $display("FAIL bad_chk: got done/cpu_reset/err=%b, required 011", {done, cpu_reset, error});
    end
    @(negedge clk);
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL writes_missing_bad: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_empty_frame();
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    n_cmp++; if (error !== 1'b1) begin n_err++; $display("FAIL garbage_kept_error: got %b, required 1", error); end
    send_byte(8'hA5, 0);
    n_cmp++; if ({done, cpu_reset, error} !== 3'b010) begin
      n_err++; $display("FAIL frame_start: got done/cpu_reset/err=%b, required 010", {done, cpu_reset, error});
    end
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    n_cmp++; if ({done, cpu_reset, error} !== 3'b100 || word_count !== '0) begin
      n_err++; $display("FAIL empty_frame: got done/cpu_reset/err=%b cnt=%0d, required 100/0", {done, cpu_reset, error}, word_count);
    end
  endtask

  task automatic test_over_length();
    send_byte(8'hA5, 0);
    send_byte(8'h80, 0);
    send_byte(8'h01, 0);
    n_cmp++; if ({done, cpu_reset, error} !== 3'b011) begin
      n_err++; $display("FAIL over_length: got done/cpu_reset/err=%b, required 011", {done, cpu_reset, error});
    end
    // Following bytes are discarded in ERROR; the scoreboard flags any write.
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    n_cmp++; if (error !== 1'b1 || word_count !== '0) begin
      n_err++; $display("FAIL over_length_hold: got err=%b cnt=%0d, required 1/0", error, word_count);
    end
  endtask

  task automatic test_interrupted();
    expect_write(15'd0, 16'hEC10);
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'hEC, 0);
    send_byte(8'h10, 0);
    send_byte(8'hE3, 0);
    reset = 1'b0;
    #1;
    n_cmp++; if ({in_ready, rom_we, cpu_reset, done, error} !== 5'b00100 || word_count !== '0 || rom_addr !== '0) begin
      n_err++; $display("FAIL async_reset: got rdy/we/cpu/done/err=%b cnt=%0d addr=%0h, required 00100/0/0",
                        {in_ready, rom_we, cpu_reset, done, error}, word_count, rom_addr);
    end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL writes_missing_intr: got %0d left, required 0", exp_q.size()); end
    apply_reset();
    expect_write(15'd0, 16'h1234);
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h46, 0);
    n_cmp++; if ({done, cpu_reset, error} !== 3'b100 || word_count !== 16'd1) begin
      n_err++; $display("FAIL reload: got done/cpu_reset/err=%b cnt=%0d, required 100/1", {done, cpu_reset, error}, word_count);
    end
    @(negedge clk);
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL writes_missing_reload: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_throttled();
    logic [7:0] frame [8];
    frame = '{8'hA5, 8'h00, 8'h02, 8'hEC, 8'h10, 8'hE3, 8'h08, 8'hE7};
    expect_write(15'd0, 16'hEC10);
    expect_write(15'd1, 16'hE308);
    for (int i = 0; i < 8; i++) begin
      send_byte(frame[i], $urandom_range(0, 4));
      if (i == 7) begin
        n_cmp++; if ({done, cpu_reset, error} !== 3'b100 || word_count !== 16'd2) begin
          n_err++; $display("FAIL throttled_release: got done/cpu_reset/err=%b cnt=%0d, required 100/2", {done, cpu_reset, error}, word_count);
        end
      end else begin
        n_cmp++; if (done !== 1'b0 || cpu_reset !== 1'b1) begin
          n_err++; $display("FAIL throttled_hold_%0d: got done=%b cpu_reset=%b, required 0/1", i, done, cpu_reset);
        end
      end
    end
    @(negedge clk);
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL writes_missing_thr: got %0d left, required 0", exp_q.size()); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_two_word();
    test_magic_in_done();
    test_bad_checksum();
    test_empty_frame();
    test_over_length();
    test_interrupted();
    test_throttled();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

endmodule
